// File: rtl/hci_core_outstanding_tracker_pkg.sv
// Shared constants for the HCI outstanding-request tracker slice.
// - HCI_MAX_OUTSTANDING_DEFAULT : default in-flight request cap
// - HCI_* widths                : field widths of the hci_core_intf bundle
// - ptr_width()                 : pointer width for a circular buffer of a given depth
package hci_core_outstanding_tracker_pkg;

   localparam int HCI_MAX_OUTSTANDING_DEFAULT = 4;

   localparam int HCI_DW      = 32;
   localparam int HCI_AW      = 32;
   localparam int HCI_BW      = HCI_DW / 8;
   localparam int HCI_UW      = 2;
   localparam int HCI_OW      = 1;
   localparam int HCI_BOFFS_W = 2;

   // A depth-1 buffer still needs a 1-bit pointer to keep the vectors legal.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/hci_core_intf.sv
// HCI core request/response bundle.
// - master modport : initiator side (drives req, payload, lrdy; receives gnt, response)
// - slave modport  : target side (receives req, payload, lrdy; drives gnt, response)
interface hci_core_intf;

   logic                                                  req;
   logic                                                  gnt;
   logic [hci_core_outstanding_tracker_pkg::HCI_AW-1:0]      add;
   logic [hci_core_outstanding_tracker_pkg::HCI_DW-1:0]      data;
   logic [hci_core_outstanding_tracker_pkg::HCI_BW-1:0]      be;
   logic                                                  we_n;
   logic [hci_core_outstanding_tracker_pkg::HCI_BOFFS_W-1:0] boffs;
   logic [hci_core_outstanding_tracker_pkg::HCI_UW-1:0]      user;
   logic [hci_core_outstanding_tracker_pkg::HCI_DW-1:0]      r_data;
   logic                                                  r_valid;
   logic [hci_core_outstanding_tracker_pkg::HCI_OW-1:0]      r_opc;
   logic [hci_core_outstanding_tracker_pkg::HCI_UW-1:0]      r_user;
   logic                                                  lrdy;

   modport master (
      output req, add, data, be, we_n, boffs, user, lrdy,
      input  gnt, r_data, r_valid, r_opc, r_user
   );

   modport slave (
      input  req, add, data, be, we_n, boffs, user, lrdy,
      output gnt, r_data, r_valid, r_opc, r_user
   );

endinterface

// File: rtl/hci_core_outstanding_tag_fifo.sv
// In-order 1-bit tag FIFO holding we_n of every granted request.
// - push_i/push_data_i : store a tag at the write pointer (ignored when full)
// - pop_i              : retire the head tag (ignored when empty)
// - flush_i            : synchronous reset of pointers and count
// - head_o             : tag at the read pointer; registered storage, no fall-through
// - count_o/full_o/empty_o : occupancy status
module hci_core_outstanding_tag_fifo
   import hci_core_outstanding_tracker_pkg::*;
#(
   parameter int DEPTH = HCI_MAX_OUTSTANDING_DEFAULT,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             push_data_i,
   input  logic             pop_i,
   output logic             head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int              PTR_W = ptr_width(DEPTH);
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

   logic [DEPTH-1:0] r_mem;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (r_count == CNT_W'(DEPTH));
   assign empty_o = (r_count == '0);
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   assign head_o  = r_mem[r_rd_ptr];
   assign count_o = r_count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/hci_core_outstanding_tracker.sv
// Outstanding-request tracker between the HCI r_valid filter and the TCDM
// interconnect. Caps in-flight requests and, optionally, suppresses r_valid
// of write responses using an in-order we_n tag FIFO.
// - clk_i, rst_ni          : clock, async active-low reset
// - clear_i                : synchronous flush of tracker state (wins over push/pop)
// - enable_i               : 0 = transparent pass-through with state frozen
// - tcdm_slave             : toward the accelerator-side filter
// - tcdm_master            : toward the interconnect
// - outstanding_o          : granted requests still awaiting a response
// - full_o                 : outstanding_o == MAX_OUTSTANDING
// - err_o                  : sticky, response seen with nothing outstanding
module hci_core_outstanding_tracker
   import hci_core_outstanding_tracker_pkg::*;
#(
   parameter int MAX_OUTSTANDING = HCI_MAX_OUTSTANDING_DEFAULT,
   parameter bit FILTER_WRITES   = 1'b1,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             enable_i,
   hci_core_intf.slave      tcdm_slave,
   hci_core_intf.master     tcdm_master,
   output logic [CNT_W-1:0] outstanding_o,
   output logic             full_o,
   output logic             err_o
);

   logic w_full;
   logic w_empty;
   logic w_fifo_head;
   logic w_head_we_n;
   logic w_resp;
   logic w_push;
   logic w_pop;
   logic w_empty_pop;
   logic r_err;

   assign tcdm_master.add    = tcdm_slave.add;
   assign tcdm_master.data   = tcdm_slave.data;
   assign tcdm_master.be     = tcdm_slave.be;
   assign tcdm_master.we_n   = tcdm_slave.we_n;
   assign tcdm_master.boffs  = tcdm_slave.boffs;
   assign tcdm_master.user   = tcdm_slave.user;
   assign tcdm_master.lrdy   = tcdm_slave.lrdy;
   assign tcdm_slave.r_data  = tcdm_master.r_data;
   assign tcdm_slave.r_opc   = tcdm_master.r_opc;
   assign tcdm_slave.r_user  = tcdm_master.r_user;

   // The head tag is only meaningful with something outstanding; an empty
   // FIFO reports a write tag so nothing can leak through the filter.
   assign w_head_we_n = ~w_empty & w_fifo_head;
   assign w_resp      = tcdm_master.r_valid & tcdm_slave.lrdy;
   // Grant toward the slave is master.gnt gated by full, so a full tracker
   // cannot push even if the interconnect grants; refill waits a cycle.
   assign w_push      = enable_i & tcdm_slave.req & tcdm_master.gnt & ~w_full;
   assign w_pop       = enable_i & w_resp & ~w_empty;
   assign w_empty_pop = enable_i & w_resp & w_empty;

   always_comb begin
      tcdm_master.req    = tcdm_slave.req;
      tcdm_slave.gnt     = tcdm_master.gnt;
      tcdm_slave.r_valid = tcdm_master.r_valid;
      if (enable_i) begin
         tcdm_master.req    = tcdm_slave.req & ~w_full;
         tcdm_slave.gnt     = tcdm_master.gnt & ~w_full;
         tcdm_slave.r_valid = ~w_empty & tcdm_master.r_valid &
                              (FILTER_WRITES ? w_head_we_n : 1'b1);
      end
   end

   // Pop retires the registered head before the same-cycle push lands, so a
   // simultaneous response always consumes the older tag.
   hci_core_outstanding_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .CNT_W (CNT_W)
   ) u_tag_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (clear_i),
      .push_i      (w_push),
      .push_data_i (tcdm_slave.we_n),
      .pop_i       (w_pop),
      .head_o      (w_fifo_head),
      .count_o     (outstanding_o),
      .full_o      (w_full),
      .empty_o     (w_empty)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_err <= 1'b0;
      end else if (clear_i) begin
         r_err <= 1'b0;
      end else if (w_empty_pop) begin
         r_err <= 1'b1;
      end
   end

   assign full_o = w_full;
   assign err_o  = r_err;

endmodule
